// File: rtl/io_bus_pkg.sv
// Shared types and constants for the MC14500B 1-bit IO bus initiator.
package io_bus_pkg;

  localparam int IO_BUS_ADDR_WIDTH = 4;
  localparam int MAX_TIMING_CYCLES = 15;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    SAMPLE
  } io_bus_state_t;

  typedef struct packed {
    logic                         write;
    logic [IO_BUS_ADDR_WIDTH-1:0] addr;
    logic                         wdata;
  } io_bus_cmd_t;

endpackage

// File: rtl/io_bus_timer.sv
// Loadable 4-bit down-counter timing the SETUP and STROBE phases of the IO bus.
module io_bus_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_value,
  output logic       zero
);

  logic [3:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  // Flags the enabled cycle whose closing edge takes the count to zero.
  assign zero = en && (count_q == 4'd1);

endmodule

// File: rtl/io_bus_master.sv
// Bus initiator sequencing single-bit read/write commands onto the IO block.
// Define IO_BUS_ADDR_CHECK_EN to reject writes to inputs and reads of outputs.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int OUTPUT_SIZE   = 2 ** (ADDR_WIDTH - 1),
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_data,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_write,
  output logic                  bus_data_out,
  input  logic                  bus_data_in
);

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES);

  io_bus_state_t state;
  io_bus_cmd_t   cmd_q;
  logic          handshake;
  logic          reject;
  logic          accept;
  logic          timer_load;
  logic          timer_en;
  logic          timer_zero;
  logic [3:0]    timer_value;

  assign cmd_ready = (state == IDLE);
  assign handshake = cmd_valid && cmd_ready;

`ifdef IO_BUS_ADDR_CHECK_EN
  localparam logic [ADDR_WIDTH:0] OUT_LIMIT = (ADDR_WIDTH + 1)'(OUTPUT_SIZE);
  logic addr_is_output;
  assign addr_is_output = ({1'b0, cmd_addr} < OUT_LIMIT);
  assign reject         = cmd_write ? !addr_is_output : addr_is_output;
`else
  assign reject = 1'b0;
`endif

  assign accept      = handshake && !reject;
  assign timer_en    = (state == SETUP) || (state == STROBE);
  assign timer_load  = accept || ((state == SETUP) && timer_zero && cmd_q.write);
  assign timer_value = accept ? SETUP_LOAD : STROBE_LOAD;

  io_bus_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // The command latch is the bus drive: it only moves on an accepted handshake.
  assign bus_address  = ADDR_WIDTH'(cmd_q.addr);
  assign bus_data_out = cmd_q.wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_q     <= '0;
      bus_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
      rsp_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (handshake) begin
            if (reject) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
            end else begin
              cmd_q <= '{write: cmd_write,
                         addr:  IO_BUS_ADDR_WIDTH'(cmd_addr),
                         wdata: cmd_wdata};
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (timer_zero) begin
            if (cmd_q.write) begin
              state     <= STROBE;
              bus_write <= 1'b1;
            end else begin
              state <= SAMPLE;
            end
          end
        end
        STROBE: begin
          if (timer_zero) begin
            state     <= HOLD;
            bus_write <= 1'b0;
          end
        end
        HOLD: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
        end
        SAMPLE: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_data  <= bus_data_in;
        end
        default: state <= IDLE;
      endcase
    end
  end

  param_legal: assert property (@(posedge clk) disable iff (reset)
    (SETUP_CYCLES >= 1) && (SETUP_CYCLES <= MAX_TIMING_CYCLES) &&
    (STROBE_CYCLES >= 1) && (STROBE_CYCLES <= MAX_TIMING_CYCLES) &&
    (OUTPUT_SIZE >= 0) && (OUTPUT_SIZE <= 2 ** ADDR_WIDTH) &&
    (ADDR_WIDTH <= IO_BUS_ADDR_WIDTH));

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master: default timing instance and a 3/2 timing instance.
module tb_io_bus_master;

  typedef struct {
    int         hs;
    int         lat;
    int         wr_lo;
    int         wr_hi;
    logic [3:0] addr;
    logic       wdata;
    logic       data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_write, cmd_wdata;
  logic [3:0] cmd_addr;
  logic       v0, rdy0, rv0, rd0, re0, bw0, bdo0, bdi0;
  logic       v1, rdy1, rv1, rd1, re1, bw1, bdo1, bdi1;
  logic [3:0] ba0, ba1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t none;
  logic [3:0] last0a = '0, last1a = '0, model0a = '0, model1a = '0;
  logic       last0d = 1'b0, last1d = 1'b0, model0d = 1'b0, model1d = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  io_bus_master u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rv0), .rsp_data(rd0),
    .rsp_error(re0), .bus_address(ba0), .bus_write(bw0), .bus_data_out(bdo0),
    .bus_data_in(bdi0)
  );

  io_bus_master #(.ADDR_WIDTH(4), .SETUP_CYCLES(3), .STROBE_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rv1), .rsp_data(rd1),
    .rsp_error(re1), .bus_address(ba1), .bus_write(bw1), .bus_data_out(bdo1),
    .bus_data_in(bdi1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input string tag, input bit have, input exp_t e,
                     input logic [3:0] la, input logic ld,
                     input logic rv, input logic rd, input logic re, input logic bw,
                     input logic [3:0] ba, input logic bd, output bit pop);
    bit in_win;
    pop    = 1'b0;
    in_win = have && (cyc > e.hs);
    chk({tag, "_bus_address"}, ba, in_win ? e.addr : la);
    chk({tag, "_bus_data_out"}, bd, in_win ? e.wdata : ld);
    chk({tag, "_bus_write"}, bw, have && (cyc >= e.wr_lo) && (cyc <= e.wr_hi));
    if (rv || (have && (cyc >= e.hs + e.lat))) begin
      chk({tag, "_rsp_valid"}, rv, have && (cyc == e.hs + e.lat));
      if (have) begin
        chk({tag, "_rsp_data"}, rd, e.data);
        chk({tag, "_rsp_error"}, re, e.err);
        pop = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t h;
    bit   pop;
    if (!reset) begin
      h = none;
      if (q0.size() > 0) h = q0[0];
      mon("d0", q0.size() > 0, h, last0a, last0d, rv0, rd0, re0, bw0, ba0, bdo0, pop);
      if (pop) begin
        h = q0.pop_front();
        last0a = h.addr;
        last0d = h.wdata;
      end
    end
  end

  always @(negedge clk) begin
    exp_t h;
    bit   pop;
    if (!reset) begin
      h = none;
      if (q1.size() > 0) h = q1[0];
      mon("d1", q1.size() > 0, h, last1a, last1d, rv1, rd1, re1, bw1, ba1, bdo1, pop);
      if (pop) begin
        h = q1.pop_front();
        last1a = h.addr;
        last1d = h.wdata;
      end
    end
  end

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic issue(input int d, input logic w, input logic [3:0] a, input logic wd,
                       input logic exp_d, input bit rej, input bit keep, input bit b2b);
    exp_t e;
    int   s, stb;
    int   n = 0;
    s   = (d == 0) ? 1 : 3;
    stb = (d == 0) ? 1 : 2;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = wd;
    if (d == 0) v0 = 1'b1; else v1 = 1'b1;
    while (!((d == 0) ? rdy0 : rdy1)) begin
      if (n == 40) begin
        chk("issue_ready_timeout", (d == 0) ? rdy0 : rdy1, 1);
        v0 = 1'b0;
        v1 = 1'b0;
        return;
      end
      n++;
      @(negedge clk);
    end
    if (b2b) chk("b2b_rsp_with_handshake", rv0, 1);
    e.hs = cyc;
    if (rej) begin
      e.lat   = 1;
      e.wr_lo = 0;
      e.wr_hi = -1;
      e.addr  = (d == 0) ? model0a : model1a;
      e.wdata = (d == 0) ? model0d : model1d;
      e.data  = 1'b0;
      e.err   = 1'b1;
    end else begin
      e.lat   = w ? (s + stb + 2) : (s + 2);
      e.wr_lo = w ? (cyc + 1 + s) : 0;
      e.wr_hi = w ? (cyc + s + stb) : -1;
      e.addr  = a;
      e.wdata = wd;
      e.data  = w ? 1'b0 : exp_d;
      e.err   = 1'b0;
      if (d == 0) begin model0a = a; model0d = wd; end
      else begin model1a = a; model1d = wd; end
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    if (!keep) begin
      v0 = 1'b0;
      v1 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0) begin
      if (n == 40) begin
        chk("drain_timeout", (d == 0) ? q0.size() : q1.size(), 0);
        q0.delete();
        q1.delete();
        return;
      end
      n++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = 1'b0;
    bdi0 = 1'b0; bdi1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", rdy0, 1);
    chk("reset_rsp_valid", rv0, 0);
    chk("reset_rsp_data", rd0, 0);
    chk("reset_rsp_error", re0, 0);
    chk("reset_bus_write", bw0, 0);
    chk("reset_bus_address", ba0, 0);
    chk("reset_bus_data_out", bdo0, 0);
    chk("reset_d1_cmd_ready", rdy1, 1);
    #1 reset = 1'b0;
    @(negedge clk);

    issue(0, 1'b1, 4'd2, 1'b1, 1'b0, 0, 0, 0);  wait_idle(0);
    bdi0 = 1'b1;
    issue(0, 1'b0, 4'd9, 1'b0, 1'b1, 0, 0, 0);  wait_idle(0);
    bdi0 = 1'b0;
    issue(0, 1'b0, 4'd10, 1'b0, 1'b0, 0, 0, 0); wait_idle(0);

    issue(1, 1'b1, 4'd6, 1'b1, 1'b0, 0, 0, 0);  wait_idle(1);
    bdi1 = 1'b1;
    issue(1, 1'b0, 4'd15, 1'b0, 1'b1, 0, 0, 0); wait_idle(1);

    bdi0 = 1'b1;
    issue(0, 1'b1, 4'd5, 1'b0, 1'b0, 0, 1, 0);
    issue(0, 1'b0, 4'd8, 1'b0, 1'b1, 0, 0, 1);
    wait_idle(0);

    issue(0, 1'b1, 4'd3, 1'b1, 1'b0, 0, 0, 0);
    n = 0;
    while (!bw0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_reached", bw0, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_bus_write", bw0, 0);
    chk("async_reset_cmd_ready", rdy0, 1);
    chk("async_reset_bus_address", ba0, 0);
    q0.delete(); q1.delete();
    last0a = '0; last0d = 1'b0; model0a = '0; model0d = 1'b0;
    last1a = '0; last1d = 1'b0; model1a = '0; model1d = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_reset_cmd_ready", rdy0, 1);
    issue(0, 1'b1, 4'd7, 1'b0, 1'b0, 0, 0, 0); wait_idle(0);

`ifdef IO_BUS_ADDR_CHECK_EN
    issue(0, 1'b1, 4'd12, 1'b1, 1'b0, 1, 0, 0); wait_idle(0);
    issue(0, 1'b0, 4'd2, 1'b0, 1'b0, 1, 0, 0);  wait_idle(0);
    issue(0, 1'b0, 4'd9, 1'b0, 1'b1, 0, 0, 0);  wait_idle(0);
`else
    issue(0, 1'b1, 4'd12, 1'b1, 1'b0, 0, 0, 0); wait_idle(0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
# io_bus_master

Bus initiator for the 1-bit IO bus of the MC14500B system. Accepts single-bit read/write commands over a valid/ready handshake and sequences them onto the IO block's address/write/data lines with programmable setup and strobe timing. Read data and completion return on a one-cycle response pulse. Sits between the control-unit sequencer, or a debug/test port, and the IO block.

## Interface
- ADDR_WIDTH, 4, width of the IO address bus
- OUTPUT_SIZE, 2 ** (ADDR_WIDTH - 1), addresses 0..OUTPUT_SIZE-1 are output latches; OUTPUT_SIZE..2**ADDR_WIDTH-1 are input pins
- SETUP_CYCLES, 1, cycles address/data are stable before strobe or sample; legal 1..15
- STROBE_CYCLES, 1, width of the write pulse in cycles; legal 1..15

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target IO address
- cmd_wdata  in  1  write data bit
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  1  read data; 0 for writes
- rsp_error  out  1  command rejected (see Configuration)
- bus_address  out  ADDR_WIDTH  to IO block address
- bus_write  out  1  to IO block write
- bus_data_out  out  1  to IO block data_in
- bus_data_in  in  1  from IO block data_out

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, SAMPLE.
- IDLE: cmd_ready=1. Handshake when cmd_valid && cmd_ready at a rising edge: latch cmd_write/addr/wdata, load counter with SETUP_CYCLES, go SETUP.
- SETUP: bus_address/bus_data_out driven from the latch, bus_write=0; counter decrements; at expiry go STROBE (write) or SAMPLE (read).
- STROBE: bus_write=1 for exactly STROBE_CYCLES cycles, then HOLD.
- HOLD: one cycle, bus_write=0, address/data still held; then IDLE with rsp_valid=1, rsp_data=0.
- SAMPLE: one cycle; bus_data_in registered at its closing edge; then IDLE with rsp_valid=1, rsp_data=sampled bit.
- bus_address/bus_data_out stay constant from SETUP through HOLD/SAMPLE and keep their last value in IDLE. They change only on a handshake.
- rsp_valid is a registered single-cycle pulse, with no back-pressure. cmd_ready is 1 in that same cycle, so back-to-back commands are legal.
- cmd_* are ignored outside IDLE.
- Counter width is 4 bits, down-counting; a value of 0 is never loaded.

## Timing
- Reset (async): state IDLE; cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_error=0, bus_write=0, bus_address=0, bus_data_out=0. bus_write drops immediately, not at the next edge.
- Reset mid-transaction: transaction is abandoned and no response is produced.
- Write latency, handshake edge to rsp_valid: SETUP_CYCLES + STROBE_CYCLES + 2 cycles. Default: 4.
- Read latency: SETUP_CYCLES + 2 cycles. Default: 3.
- Sustained throughput: one command per latency period; no idle bubble is required between commands.

## Configuration
- IO_BUS_ADDR_CHECK_EN defined:
  - A write with cmd_addr >= OUTPUT_SIZE, or a read with cmd_addr < OUTPUT_SIZE, is accepted but never placed on the bus.
  - FSM stays IDLE, and bus_* are unchanged.
  - Next cycle: rsp_valid=1, rsp_error=1, rsp_data=0.
- Not defined: all commands execute; rsp_error is tied to 0.

## Structure
- io_bus_pkg holds:
  - the state enum typedef io_bus_state_t;
  - command struct io_bus_cmd_t (write, addr, wdata), parameterised by a package ADDR_WIDTH constant;
  - localparam MAX_TIMING_CYCLES = 15.
- Sub-module io_bus_timer: loadable 4-bit down-counter with load, enable and zero outputs, used for both SETUP and STROBE.

## Test plan
- Reset, then write addr 2 data 1 with defaults -> bus_address=2 and bus_data_out=1 from cycle 1; bus_write=1 only in cycle 2; rsp_valid in cycle 4 with rsp_data=0.
- Read addr 9 with bus_data_in=1 (defaults) -> bus_write stays 0; rsp_valid in cycle 3 with rsp_data=1.
- SETUP_CYCLES=3, STROBE_CYCLES=2, write -> bus_write high for exactly 2 cycles starting 3 cycles after the handshake; rsp_valid 7 cycles after the handshake.
- Back-to-back: cmd_valid held high with a write then a read -> second handshake in the same cycle as the first rsp_valid; address stable throughout each transaction.
- Assert reset during STROBE -> bus_write=0 asynchronously; no rsp_valid; cmd_ready=1 after release.
- With IO_BUS_ADDR_CHECK_EN, write to addr 12 (ADDR_WIDTH=4) -> no bus activity; rsp_valid=1 and rsp_error=1 one cycle after the handshake.
